// File: rtl/paper_pkg.sv
// Shared register map, response codes and types for the Paper peripheral.
package paper_pkg;

    localparam logic [11:0] OffId      = 12'h000;
    localparam logic [11:0] OffCtrl    = 12'h004;
    localparam logic [11:0] OffScratch = 12'h008;
    localparam logic [11:0] OffCount   = 12'h00C;
    localparam logic [11:0] OffCompare = 12'h010;

    localparam logic [31:0] IdValue = 32'h5041_5045;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlClrBit   = 1;
    localparam int unsigned CtrlIrqEnBit = 2;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExOkay = 2'b01,
        RespSlvErr = 2'b10,
        RespDecErr = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        RegNone,
        RegId,
        RegCtrl,
        RegScratch,
        RegCount,
        RegCompare
    } reg_e;

    typedef struct packed {
        resp_e resp;
        reg_e  sel;
    } dec_t;

    typedef enum logic [0:0] {WIdle, WResp} wstate_e;
    typedef enum logic [0:0] {RIdle, RResp} rstate_e;

    // Byte-lane merge of new_val into old_val.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_pkg.sv
// SoC address map entries used by the peripherals in this slice.
package soc_pkg;

    localparam logic [63:0] PaperBase   = 64'h1900_0000;
    localparam logic [63:0] PaperLength = 64'h1000;

endpackage

// File: rtl/paper_counter.sv
// Free-running COUNT with clear, COMPARE register and sticky compare interrupt.
module paper_counter
    import paper_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic        irq_en_i,
    input  logic        compare_we_i,
    input  logic [31:0] compare_wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        irq_q, irq_d;

    // Next-state: clear beats increment; a COMPARE write or irq_en=0 drops the irq.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        irq_d     = irq_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 32'd1;
        end
        if (compare_we_i) compare_d = compare_wdata_i;
        if (compare_we_i || !irq_en_i) begin
            irq_d = 1'b0;
        end else if (count_q == compare_q) begin
            irq_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            irq_q     <= irq_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign irq_o     = irq_q;

endmodule

// File: rtl/paper_axi_lite_slave.sv
// AXI-Lite register slave for the Paper peripheral (ID, CTRL, SCRATCH, COUNT, COMPARE).
module paper_axi_lite_slave
    import paper_pkg::*;
#(
    parameter logic [63:0] BaseAddr  = soc_pkg::PaperBase,
    parameter logic [63:0] Length    = soc_pkg::PaperLength,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [1:0]             b_resp_o,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic                   irq_o
);

    localparam logic [AddrWidth-1:0] BaseA = BaseAddr[AddrWidth-1:0];
    localparam logic [AddrWidth-1:0] LenA  = Length[AddrWidth-1:0];

    function automatic dec_t decode(input logic [AddrWidth-1:0] addr, input logic is_wr);
        logic [AddrWidth-1:0] off;
        dec_t d;
        off    = addr - BaseA;
        d.resp = RespSlvErr;
        d.sel  = RegNone;
        if (addr < BaseA || off >= LenA) begin
            d.resp = RespDecErr;
        end else if (off[1:0] == 2'b00) begin
            if (off == AddrWidth'(OffId) && !is_wr)         d.sel = RegId;
            else if (off == AddrWidth'(OffCtrl))            d.sel = RegCtrl;
            else if (off == AddrWidth'(OffScratch))         d.sel = RegScratch;
            else if (off == AddrWidth'(OffCount) && !is_wr) d.sel = RegCount;
            else if (off == AddrWidth'(OffCompare))         d.sel = RegCompare;
            if (d.sel != RegNone) d.resp = RespOkay;
        end
        return d;
    endfunction

    wstate_e              wstate_q, wstate_d;
    rstate_e              rstate_q, rstate_d;
    logic                 aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
    logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
    logic [31:0]          w_data_q, w_data_d;
    logic [3:0]           w_strb_q, w_strb_d;
    logic [1:0]           b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [31:0]          r_data_q, r_data_d, rd_val;
    logic                 do_write;
    dec_t                 wdec, rdec;

    logic                 en_q, en_d, irq_en_q, irq_en_d;
    logic [31:0]          scratch_q, scratch_d;
    logic [2:0]           ctrl_new;
    logic                 clear_pulse, compare_we;
    logic [31:0]          compare_wdata, compare_val, count_val;

    // Write FSM: latch AW and W independently; commit once both are held.
    always_comb begin
        wstate_d   = wstate_q;
        aw_lat_d   = aw_lat_q;
        aw_addr_d  = aw_addr_q;
        w_lat_d    = w_lat_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_resp_d   = b_resp_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        do_write   = 1'b0;
        unique case (wstate_q)
            WIdle: begin
                aw_ready_o = !aw_lat_q;
                w_ready_o  = !w_lat_q;
                if (aw_valid_i && !aw_lat_q) begin
                    aw_lat_d  = 1'b1;
                    aw_addr_d = aw_addr_i;
                end
                if (w_valid_i && !w_lat_q) begin
                    w_lat_d  = 1'b1;
                    w_data_d = w_data_i;
                    w_strb_d = w_strb_i;
                end
                if (aw_lat_d && w_lat_d) begin
                    do_write = 1'b1;
                    wstate_d = WResp;
                end
            end
            WResp: begin
                if (b_ready_i) begin
                    wstate_d = WIdle;
                    aw_lat_d = 1'b0;
                    w_lat_d  = 1'b0;
                end
            end
            default: wstate_d = WIdle;
        endcase
        wdec = decode(aw_addr_d, 1'b1);
        if (do_write) b_resp_d = wdec.resp;
    end

    // Register write decode; only OKAY writes have side effects.
    always_comb begin
        en_d          = en_q;
        irq_en_d      = irq_en_q;
        scratch_d     = scratch_q;
        clear_pulse   = 1'b0;
        compare_we    = 1'b0;
        compare_wdata = apply_strb(compare_val, w_data_d, w_strb_d);
        ctrl_new      = w_strb_d[0] ? w_data_d[2:0] : {irq_en_q, 1'b0, en_q};
        if (do_write && wdec.resp == RespOkay) begin
            case (wdec.sel)
                RegCtrl: begin
                    en_d        = ctrl_new[CtrlEnBit];
                    irq_en_d    = ctrl_new[CtrlIrqEnBit];
                    clear_pulse = ctrl_new[CtrlClrBit];
                end
                RegScratch: scratch_d  = apply_strb(scratch_q, w_data_d, w_strb_d);
                RegCompare: compare_we = 1'b1;
                default: ;
            endcase
        end
    end

    // Read FSM: capture data at the AR handshake, hold until r_ready_i.
    always_comb begin
        rdec = decode(ar_addr_i, 1'b0);
        case (rdec.sel)
            RegId:      rd_val = IdValue;
            RegCtrl:    rd_val = {29'd0, irq_en_q, 1'b0, en_q};
            RegScratch: rd_val = scratch_q;
            RegCount:   rd_val = count_val;
            RegCompare: rd_val = compare_val;
            default:    rd_val = '0;
        endcase
        rstate_d = rstate_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        unique case (rstate_q)
            RIdle: begin
                if (ar_valid_i) begin
                    r_resp_d = rdec.resp;
                    r_data_d = (rdec.resp == RespOkay) ? rd_val : '0;
                    rstate_d = RResp;
                end
            end
            RResp:   if (r_ready_i) rstate_d = RIdle;
            default: rstate_d = RIdle;
        endcase
    end

    // State registers for both channels and the flat control registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wstate_q  <= WIdle;
            rstate_q  <= RIdle;
            aw_lat_q  <= 1'b0;
            aw_addr_q <= '0;
            w_lat_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= 2'b00;
            r_resp_q  <= 2'b00;
            r_data_q  <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            scratch_q <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_lat_q  <= aw_lat_d;
            aw_addr_q <= aw_addr_d;
            w_lat_q   <= w_lat_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_resp_q  <= b_resp_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            scratch_q <= scratch_d;
        end
    end

    paper_counter u_counter (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .enable_i        (en_q),
        .clear_i         (clear_pulse),
        .irq_en_i        (irq_en_q),
        .compare_we_i    (compare_we),
        .compare_wdata_i (compare_wdata),
        .count_o         (count_val),
        .compare_o       (compare_val),
        .irq_o           (irq_o)
    );

    assign ar_ready_o = (rstate_q == RIdle);
    assign r_valid_o  = (rstate_q == RResp);
    assign r_data_o   = r_data_q;
    assign r_resp_o   = r_resp_q;
    assign b_valid_o  = (wstate_q == WResp);
    assign b_resp_o   = b_resp_q;

endmodule

// File: tb/tb_paper_axi_lite_slave.sv
// Directed self-checking bench for paper_axi_lite_slave.
module tb_paper_axi_lite_slave;

    localparam logic [63:0] Base = 64'h1900_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [63:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic        irq;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    paper_axi_lite_slave dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .aw_addr_i  (aw_addr),
        .aw_valid_i (aw_valid),
        .aw_ready_o (aw_ready),
        .w_data_i   (w_data),
        .w_strb_i   (w_strb),
        .w_valid_i  (w_valid),
        .w_ready_o  (w_ready),
        .b_resp_o   (b_resp),
        .b_valid_o  (b_valid),
        .b_ready_i  (b_ready),
        .ar_addr_i  (ar_addr),
        .ar_valid_i (ar_valid),
        .ar_ready_o (ar_ready),
        .r_data_o   (r_data),
        .r_resp_o   (r_resp),
        .r_valid_o  (r_valid),
        .r_ready_i  (r_ready),
        .irq_o      (irq)
    );

    // Bus drivers; called and returning at a negedge.
    task automatic axi_write(input logic [63:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        int cyc = 0;
        aw_addr = addr; w_data = data; w_strb = strb;
        aw_valid = 1'b1; w_valid = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            if (aw_valid && aw_ready) aw_done = 1;
            if (w_valid && w_ready) w_done = 1;
            @(negedge clk);
            if (aw_done) aw_valid = 1'b0;
            if (w_done) w_valid = 1'b0;
            cyc++;
        end
        cyc = 0;
        while (!b_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!b_valid) begin
            total++; bad++;
            $display("FAIL write_timeout addr=%h got b_valid=%b want 1", addr, b_valid);
            resp = 2'bxx;
            aw_valid = 1'b0; w_valid = 1'b0;
        end else begin
            resp = b_resp;
            b_ready = 1'b1;
            @(negedge clk);
            b_ready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [63:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic lat_ok);
        int cyc = 0;
        ar_addr = addr; ar_valid = 1'b1;
        while (!ar_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        ar_valid = 1'b0;
        lat_ok = r_valid;
        cyc = 0;
        while (!r_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!r_valid) begin
            total++; bad++;
            $display("FAIL read_timeout addr=%h got r_valid=%b want 1", addr, r_valid);
            data = 'x; resp = 2'bxx;
        end else begin
            data = r_data; resp = r_resp;
            r_ready = 1'b1;
            @(negedge clk);
            r_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        lat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, irq} !== 6'b111000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=111000",
                     {aw_ready, w_ready, ar_ready, b_valid, r_valid, irq});
        end
        total++;
        if ({b_resp, r_resp, r_data} !== 36'd0) begin
            bad++;
            $display("FAIL reset_resp got=%h want=0", {b_resp, r_resp, r_data});
        end
        axi_read(Base + 64'h4, d, rs, lat);
        total++;
        if ({rs, d} !== {2'b00, 32'h0}) begin
            bad++; $display("FAIL reset_ctrl got=%h want=%h", {rs, d}, {2'b00, 32'h0});
        end
        axi_read(Base + 64'h8, d, rs, lat);
        total++;
        if ({rs, d} !== {2'b00, 32'h0}) begin
            bad++; $display("FAIL reset_scratch got=%h want=%h", {rs, d}, {2'b00, 32'h0});
        end
        axi_read(Base + 64'h10, d, rs, lat);
        total++;
        if ({rs, d} !== {2'b00, 32'hFFFF_FFFF}) begin
            bad++; $display("FAIL reset_compare got=%h want=%h", {rs, d}, {2'b00, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_id_read();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        lat;
        axi_read(Base, d, rs, lat);
        total++;
        if ({lat, rs, d} !== {1'b1, 2'b00, 32'h5041_5045}) begin
            bad++;
            $display("FAIL id_read got=%h want=%h", {lat, rs, d}, {1'b1, 2'b00, 32'h5041_5045});
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        lat;
        w_data = 32'hDEAD_BEEF; w_strb = 4'b0011; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        total++;
        if ({aw_ready, w_ready, b_valid} !== 3'b100) begin
            bad++; $display("FAIL w_latched got=%b want=100", {aw_ready, w_ready, b_valid});
        end
        repeat (2) @(negedge clk);
        aw_addr = Base + 64'h8; aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({b_valid, b_resp, aw_ready, w_ready} !== 5'b10000) begin
                bad++;
                $display("FAIL b_hold cycle=%0d got=%b want=10000", i,
                         {b_valid, b_resp, aw_ready, w_ready});
            end
            if (i < 5) @(negedge clk);
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        total++;
        if ({b_valid, aw_ready, w_ready} !== 3'b011) begin
            bad++; $display("FAIL b_release got=%b want=011", {b_valid, aw_ready, w_ready});
        end
        axi_read(Base + 64'h8, d, rs, lat);
        total++;
        if (d !== 32'h0000_BEEF) begin
            bad++; $display("FAIL scratch_strb got=%h want=0000beef", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        lat;
        axi_write(Base + 64'hC, 32'h1234, 4'hF, rs);
        total++;
        if (rs !== 2'b10) begin bad++; $display("FAIL wr_count got=%b want=10", rs); end
        axi_read(Base + 64'hC, d, rs, lat);
        total++;
        if ({rs, d} !== 34'd0) begin bad++; $display("FAIL count_kept got=%h want=0", {rs, d}); end
        axi_read(Base + 64'h1000, d, rs, lat);
        total++;
        if ({rs, d} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL rd_decerr got=%h want=%h", {rs, d}, {2'b11, 32'h0});
        end
        axi_read(Base + 64'h6, d, rs, lat);
        total++;
        if ({rs, d} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL rd_misaligned got=%h want=%h", {rs, d}, {2'b10, 32'h0});
        end
        axi_read(Base + 64'h20, d, rs, lat);
        total++;
        if ({rs, d} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL rd_unmapped got=%h want=%h", {rs, d}, {2'b10, 32'h0});
        end
        axi_write(Base, 32'h0, 4'hF, rs);
        total++;
        if (rs !== 2'b10) begin bad++; $display("FAIL wr_id got=%b want=10", rs); end
        axi_write(Base - 64'h4, 32'h0, 4'hF, rs);
        total++;
        if (rs !== 2'b11) begin bad++; $display("FAIL wr_below got=%b want=11", rs); end
        axi_write(Base + 64'h9, 32'hFFFF_FFFF, 4'hF, rs);
        total++;
        if (rs !== 2'b10) begin bad++; $display("FAIL wr_misaligned got=%b want=10", rs); end
        axi_write(Base + 64'h8, 32'hFFFF_FFFF, 4'h0, rs);
        total++;
        if (rs !== 2'b00) begin bad++; $display("FAIL wr_strb0 got=%b want=00", rs); end
        axi_read(Base + 64'h8, d, rs, lat);
        total++;
        if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL scratch_kept got=%h want=0000beef", d); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        lat;
        axi_write(Base + 64'h8, 32'h1122_3344, 4'hF, rs);
        axi_write(Base + 64'h8, 32'hAABB_CCDD, 4'b1010, rs);
        axi_read(Base + 64'h8, d, rs, lat);
        total++;
        if (d !== 32'hAA22_CC44) begin bad++; $display("FAIL byte_lanes got=%h want=aa22cc44", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        lat;
        ar_addr = Base + 64'h8; ar_valid = 1'b1;
        aw_addr = Base + 64'h8; aw_valid = 1'b1;
        w_data = 32'h5555_5555; w_strb = 4'hF; w_valid = 1'b1;
        @(negedge clk);
        ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        total++;
        if ({r_valid, r_data, b_valid, b_resp} !== {1'b1, 32'hAA22_CC44, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL same_cycle_rw got=%h want=%h", {r_valid, r_data, b_valid, b_resp},
                     {1'b1, 32'hAA22_CC44, 1'b1, 2'b00});
        end
        r_ready = 1'b1; b_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0; b_ready = 1'b0;
        axi_read(Base + 64'h8, d, rs, lat);
        total++;
        if (d !== 32'h5555_5555) begin bad++; $display("FAIL post_write got=%h want=55555555", d); end
    endtask

    task automatic test_irq();
        logic [1:0] rs;
        int         cyc = 0;
        axi_write(Base + 64'h10, 32'd5, 4'hF, rs);
        axi_write(Base + 64'h4, 32'h5, 4'hF, rs);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b want=0", irq); end
        while (!irq && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if ({irq, dut.u_counter.count_q} !== {1'b1, 32'd6}) begin
            bad++;
            $display("FAIL irq_rise got=%h want=%h", {irq, dut.u_counter.count_q}, {1'b1, 32'd6});
        end
        repeat (3) @(negedge clk);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_sticky got=%b want=1", irq); end
        axi_write(Base + 64'h10, 32'h1000, 4'hF, rs);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", irq); end
        axi_write(Base + 64'h4, 32'h0, 4'hF, rs);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        lat;
        axi_write(Base + 64'h4, 32'h1, 4'hF, rs);
        force dut.u_counter.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_counter.count_q;
        @(negedge clk);
        total++;
        if (dut.u_counter.count_q !== 32'd0) begin
            bad++; $display("FAIL count_wrap got=%h want=0", dut.u_counter.count_q);
        end
        repeat (4) @(negedge clk);
        // Clear at the write edge, then one enabled increment before return.
        axi_write(Base + 64'h4, 32'h3, 4'hF, rs);
        total++;
        if (dut.u_counter.count_q !== 32'd1) begin
            bad++; $display("FAIL count_clear got=%h want=1", dut.u_counter.count_q);
        end
        axi_read(Base + 64'h4, d, rs, lat);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL ctrl_selfclr got=%h want=1", d); end
        axi_write(Base + 64'h4, 32'h0, 4'hF, rs);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        lat;
        aw_addr = Base + 64'h8; aw_valid = 1'b1;
        w_data = 32'h1234_5678; w_strb = 4'hF; w_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        total++;
        if (b_valid !== 1'b1) begin bad++; $display("FAIL mid_bvalid got=%b want=1", b_valid); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (b_valid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b want=0", b_valid); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
            bad++; $display("FAIL rst_ready got=%b want=111", {aw_ready, w_ready, ar_ready});
        end
        // Partially latched W must not survive reset.
        w_data = 32'hCAFE_0000; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        axi_read(Base + 64'h8, d, rs, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rst_scratch got=%h want=0", d); end
        aw_addr = Base + 64'h8; aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (b_valid !== 1'b0) begin
                bad++; $display("FAIL stale_w cycle=%0d got=%b want=0", i, b_valid);
            end
            @(negedge clk);
        end
        w_data = 32'h0000_0011; w_strb = 4'hF; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        total++;
        if ({b_valid, b_resp} !== 3'b100) begin
            bad++; $display("FAIL late_w got=%b want=100", {b_valid, b_resp});
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        axi_read(Base + 64'h8, d, rs, lat);
        total++;
        if (d !== 32'h11) begin bad++; $display("FAIL late_w_data got=%h want=11", d); end
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_w_before_aw();
        test_errors();
        test_byte_lanes();
        test_back_to_back();
        test_irq();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paper_axi_lite_slave.md
PAPER_AXI_LITE_SLAVE -- requirements
Module: paper_axi_lite_slave

Interface
REQ-001 SHALL have parameter BaseAddr, default 64'h1900_0000, start of the Paper window in the SoC map.
REQ-002 SHALL have parameter Length, default 64'h1000, window size in bytes.
REQ-003 SHALL have parameter AddrWidth, default 64, AXI-Lite address width.
REQ-004 SHALL have parameter DataWidth, default 32, fixed at 32.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, all logic rising-edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have ports aw_addr_i (AddrWidth), aw_valid_i (1), aw_ready_o (1): write-address channel.
REQ-008 SHALL have ports w_data_i (32), w_strb_i (4), w_valid_i (1), w_ready_o (1): write-data channel.
REQ-009 SHALL have ports b_resp_o (2), b_valid_o (1), b_ready_i (1): write-response channel.
REQ-010 SHALL have ports ar_addr_i (AddrWidth), ar_valid_i (1), ar_ready_o (1): read-address channel.
REQ-011 SHALL have ports r_data_o (32), r_resp_o (2), r_valid_o (1), r_ready_i (1): read-data channel.
REQ-012 SHALL have port irq_o, output, 1 bit: level interrupt to PLIC.

Function
REQ-013 SHALL decode offset = addr - BaseAddr; addr outside [BaseAddr, BaseAddr+Length) -> resp DECERR (2'b11), no side effect.
REQ-014 SHALL implement registers: 0x000 ID RO 32'h5041_5045; 0x004 CTRL RW (bit0 enable, bit1 clear, self-clearing, bit2 irq_en); 0x008 SCRATCH RW; 0x00C COUNT RO; 0x010 COMPARE RW.
REQ-015 SHALL return SLVERR (2'b10) for in-window unmapped offsets, misaligned (addr[1:0]!=0) accesses and writes to RO registers; no state change.
REQ-016 SHALL apply writes per byte lane using w_strb_i; strobe 4'b0000 -> OKAY, no change.
REQ-017 Write FSM states W_IDLE, W_RESP; in W_IDLE aw_ready_o=!aw_latched, w_ready_o=!w_latched; AW and W accepted in either order or same cycle.
REQ-018 When both AW and W are latched, register update SHALL occur on that edge and FSM SHALL enter W_RESP with b_valid_o=1 next cycle.
REQ-019 b_valid_o SHALL hold with stable b_resp_o until b_ready_i; then return to W_IDLE, clearing latches; aw_ready_o=w_ready_o=0 in W_RESP.
REQ-020 Read FSM states R_IDLE, R_RESP; ar_ready_o=1 only in R_IDLE; on handshake r_data_o/r_resp_o registered, r_valid_o=1 next cycle, held stable until r_ready_i.
REQ-021 r_data_o SHALL be 0 for any non-OKAY response.
REQ-022 COUNT SHALL increment by 1 per cycle while enable=1, wrapping 32'hFFFF_FFFF -> 0; clear bit sets COUNT=0 that cycle, overriding increment.
REQ-023 irq_o SHALL be registered: set when irq_en=1 and COUNT==COMPARE; cleared by any write to COMPARE or irq_en=0.
REQ-024 Simultaneous read and write of same register SHALL return pre-write value.
REQ-025 Read of COUNT SHALL return value at AR handshake edge.

Reset
REQ-026 On rst_i=1 at clock edge: both FSMs idle, latches cleared, b_valid_o=0, r_valid_o=0, b_resp_o=0, r_resp_o=0, r_data_o=0, irq_o=0, CTRL=0, SCRATCH=0, COUNT=0, COMPARE=32'hFFFF_FFFF.
REQ-027 Reset mid-transaction SHALL abandon pending responses; no update from partially latched AW/W.
REQ-028 aw_ready_o, w_ready_o, ar_ready_o SHALL read 1 the first cycle after reset deasserts.

Structure
REQ-029 Register offsets, ID constant, resp encodings (OKAY/SLVERR/DECERR) SHALL live in a shared paper_pkg; base/length SHALL come from the SoC package PaperBase/PaperLength.
REQ-030 One sub-module, paper_counter (COUNT, clear, compare, irq), SHALL be split out; rest flat.

Verification
REQ-031 Read 0x1900_0000 -> r_data_o=32'h5041_5045, r_resp_o=OKAY, r_valid_o one cycle after handshake.
REQ-032 W before AW (W cycle 0, AW cycle 3) to 0x1900_0008, data 32'hDEAD_BEEF, strb 4'b0011 -> SCRATCH=32'h0000_BEEF, b_resp_o OKAY; b_ready_i low 5 cycles -> b_valid_o held.
REQ-033 Write 0x1900_000C -> SLVERR, COUNT unchanged; read 0x1900_1000 -> DECERR, r_data_o=0; read 0x1900_0006 -> SLVERR.
REQ-034 COMPARE=5, CTRL=3'b101 -> irq_o=1 when COUNT reaches 5; write COMPARE -> irq_o=0 next cycle.
REQ-035 Force COUNT=32'hFFFF_FFFF with enable=1 -> next cycle 0; CTRL clear with enable=1 same cycle -> COUNT=0.
REQ-036 rst_i asserted while b_valid_o=1 -> b_valid_o=0 next cycle, aw_ready_o=1 after deassert.
